// File: rtl/vga_pkg.sv
// Shared constants and state encoding for the VGA raster timing generator.
package vga_pkg;

  localparam int unsigned VGA_REZ_MAX_WIDTH = 11;
  localparam int unsigned VGA_DEF_H_TOTAL   = 800;
  localparam int unsigned VGA_DEF_H_SYNC    = 96;
  localparam int unsigned VGA_DEF_V_TOTAL   = 525;
  localparam int unsigned VGA_DEF_V_SYNC    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } vga_state_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with end-of-axis flag and raw sync.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned W = VGA_REZ_MAX_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         step,
  input  logic [W-1:0] total,
  input  logic [W-1:0] sync_len,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         sync_raw
);

  logic [W-1:0] count_r;
  logic [W-1:0] last_s;

  // total of 0 wraps at all-ones through modular subtraction
  assign last_s   = total - W'(1);
  assign wrap     = (count_r == last_s);
  assign sync_raw = (count_r < sync_len);
  assign count    = count_r;

  // position register: clear, advance or wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (step) begin
      count_r <= wrap ? {W{1'b0}} : (count_r + W'(1));
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: frame-shadowed configuration, run/idle control,
// pixel/line counters and registered sync/strobe outputs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned REZ_MAX_WIDTH = VGA_REZ_MAX_WIDTH,
  parameter int unsigned DEF_H_TOTAL   = VGA_DEF_H_TOTAL,
  parameter int unsigned DEF_H_SYNC    = VGA_DEF_H_SYNC,
  parameter int unsigned DEF_V_TOTAL   = VGA_DEF_V_TOTAL,
  parameter int unsigned DEF_V_SYNC    = VGA_DEF_V_SYNC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     En,
  input  logic [REZ_MAX_WIDTH-1:0] H_total,
  input  logic [REZ_MAX_WIDTH-1:0] H_sync_len,
  input  logic [REZ_MAX_WIDTH-1:0] V_total,
  input  logic [REZ_MAX_WIDTH-1:0] V_sync_len,
  input  logic                     H_pol,
  input  logic                     V_pol,
  output logic [REZ_MAX_WIDTH-1:0] Count_h,
  output logic [REZ_MAX_WIDTH-1:0] Count_v,
  output logic                     HSYNC,
  output logic                     VSYNC,
  output logic                     Line_start,
  output logic                     Frame_start
);

  localparam int unsigned W = REZ_MAX_WIDTH;

  vga_state_e state_r, state_nxt_s;

  logic [W-1:0] sh_h_total_r, sh_h_sync_r, sh_v_total_r, sh_v_sync_r;
  logic         sh_h_pol_r, sh_v_pol_r;
  logic         run_s, cnt_clr_s, v_step_s, frame_wrap_s, shadow_load_s;
  logic         h_wrap_s, v_wrap_s, hs_raw_s, vs_raw_s;
  logic         hsync_r, vsync_r, line_start_r, frame_start_r;

  // next-state decode: En alone decides, even mid-frame
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (En) state_nxt_s = RUN;
        else    state_nxt_s = IDLE;
      end
      RUN: begin
        if (En) state_nxt_s = RUN;
        else    state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  assign run_s         = (state_r == RUN) && En;
  assign cnt_clr_s     = !run_s;
  assign v_step_s      = run_s && h_wrap_s;
  // a frame wrap still reloads the shadows when En falls on the same cycle
  assign frame_wrap_s  = (state_r == RUN) && h_wrap_s && v_wrap_s;
  assign shadow_load_s = ((state_r == IDLE) && En) || frame_wrap_s;

  // configuration shadows, refreshed only at frame boundaries or on start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_h_total_r <= W'(DEF_H_TOTAL);
      sh_h_sync_r  <= W'(DEF_H_SYNC);
      sh_v_total_r <= W'(DEF_V_TOTAL);
      sh_v_sync_r  <= W'(DEF_V_SYNC);
      sh_h_pol_r   <= 1'b0;
      sh_v_pol_r   <= 1'b0;
    end else if (shadow_load_s) begin
      sh_h_total_r <= H_total;
      sh_h_sync_r  <= H_sync_len;
      sh_v_total_r <= V_total;
      sh_v_sync_r  <= V_sync_len;
      sh_h_pol_r   <= H_pol;
      sh_v_pol_r   <= V_pol;
    end
  end

  vga_axis_counter #(.W(W)) u_h_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr_s),
    .step     (run_s),
    .total    (sh_h_total_r),
    .sync_len (sh_h_sync_r),
    .count    (Count_h),
    .wrap     (h_wrap_s),
    .sync_raw (hs_raw_s)
  );

  vga_axis_counter #(.W(W)) u_v_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr_s),
    .step     (v_step_s),
    .total    (sh_v_total_r),
    .sync_len (sh_v_sync_r),
    .count    (Count_v),
    .wrap     (v_wrap_s),
    .sync_raw (vs_raw_s)
  );

  // output pipeline: one cycle behind the counters to match the colour stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_r       <= 1'b1;
      vsync_r       <= 1'b1;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else if (run_s) begin
      hsync_r       <= hs_raw_s ~^ sh_h_pol_r;
      vsync_r       <= vs_raw_s ~^ sh_v_pol_r;
      line_start_r  <= (Count_h == {W{1'b0}});
      frame_start_r <= (Count_h == {W{1'b0}}) && (Count_v == {W{1'b0}});
    end else begin
      hsync_r       <= ~sh_h_pol_r;
      vsync_r       <= ~sh_v_pol_r;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end
  end

  assign HSYNC       = hsync_r;
  assign VSYNC       = vsync_r;
  assign Line_start  = line_start_r;
  assign Frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized self-checking bench for vga_timing_gen against a linear-position raster model.
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [10:0] h_total, h_sync_len, v_total, v_sync_len;
  logic        h_pol, v_pol;
  wire  [10:0] count_h, count_v;
  wire         hsync, vsync, line_start, frame_start;

  int checks = 0;
  int failures = 0;

  // model: position within the frame as one linear pixel index
  int m_run, m_pos, m_ht, m_hs, m_vt, m_vs, m_hp, m_vp;
  int e_hs, e_vs, e_ls, e_fs;

  vga_timing_gen dut (
    .clk(clk), .rst_n(rst_n), .En(en),
    .H_total(h_total), .H_sync_len(h_sync_len),
    .V_total(v_total), .V_sync_len(v_sync_len),
    .H_pol(h_pol), .V_pol(v_pol),
    .Count_h(count_h), .Count_v(count_v),
    .HSYNC(hsync), .VSYNC(vsync),
    .Line_start(line_start), .Frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int span(input int t);
    return (t == 0) ? 2048 : t;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pos = 0;
    m_ht = VGA_DEF_H_TOTAL; m_hs = VGA_DEF_H_SYNC;
    m_vt = VGA_DEF_V_TOTAL; m_vs = VGA_DEF_V_SYNC;
    m_hp = 0; m_vp = 0;
    e_hs = 1; e_vs = 1; e_ls = 0; e_fs = 0;
  endtask

  task automatic model_step();
    int ht, vt, mh, mv, active, frame_end, load;
    ht = span(m_ht); vt = span(m_vt);
    mh = m_pos % ht; mv = m_pos / ht;
    active = (m_run != 0) && en;
    if (active != 0) begin
      e_hs = ((mh < m_hs) ? 1 : 0) == m_hp;
      e_vs = ((mv < m_vs) ? 1 : 0) == m_vp;
      e_ls = (mh == 0);
      e_fs = (m_pos == 0);
    end else begin
      e_hs = (m_hp == 0); e_vs = (m_vp == 0); e_ls = 0; e_fs = 0;
    end
    frame_end = (m_run != 0) && (m_pos == ht * vt - 1);
    load = ((m_run == 0) && en) || (frame_end != 0);
    if (active != 0) m_pos = (frame_end != 0) ? 0 : m_pos + 1;
    else             m_pos = 0;
    m_run = en;
    if (load != 0) begin
      m_ht = h_total; m_hs = h_sync_len; m_vt = v_total; m_vs = v_sync_len;
      m_hp = h_pol; m_vp = v_pol;
    end
  endtask

  task automatic compare_all();
    chk("count_h", int'(count_h), m_pos % span(m_ht));
    chk("count_v", int'(count_v), m_pos / span(m_ht));
    chk("hsync", int'(hsync), e_hs);
    chk("vsync", int'(vsync), e_vs);
    chk("line_start", int'(line_start), e_ls);
    chk("frame_start", int'(frame_start), e_fs);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_cfg(input int ht, input int hs, input int vt, input int vs,
                         input int hp, input int vp);
    h_total = 11'(ht); h_sync_len = 11'(hs);
    v_total = 11'(vt); v_sync_len = 11'(vs);
    h_pol = 1'(hp); v_pol = 1'(vp);
  endtask

  task automatic rand_cfg();
    int ht, vt;
    ht = $urandom_range(8, 40);
    vt = $urandom_range(2, 10);
    set_cfg(ht, $urandom_range(0, ht + 3), vt, $urandom_range(0, vt + 2),
            $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  task automatic async_reset_pulse();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1 rst_n = 1'b1;
  endtask

  task automatic run_until_h(input int target, input int budget);
    int n;
    n = 0;
    while ((m_pos % span(m_ht)) != target && n < budget) begin
      cycle();
      n++;
    end
    chk("reach_h_bound", (n < budget) ? 1 : 0, 1);
  endtask

  initial begin
    set_cfg(VGA_DEF_H_TOTAL, VGA_DEF_H_SYNC, VGA_DEF_V_TOTAL, VGA_DEF_V_SYNC, 0, 0);
    model_reset();
    #12;
    compare_all();
    rst_n = 1'b1;
    repeat (3) cycle();

    // default 640x480 timing for a couple of lines
    en = 1'b1;
    repeat (1700) cycle();

    // drop En mid-line, then restart from the origin
    run_until_h(300, 2000);
    en = 1'b0;
    repeat (4) cycle();
    en = 1'b1;
    repeat (50) cycle();

    // small frame loaded through an En restart
    en = 1'b0;
    set_cfg(30, 4, 6, 1, 0, 0);
    cycle();
    en = 1'b1;
    repeat (100) cycle();

    // mid-frame change must wait for the frame wrap
    set_cfg(44, 50, 5, 0, 1, 1);
    repeat (600) cycle();

    // degenerate sync lengths
    set_cfg(800, 0, 3, 1, 0, 0);
    repeat (5000) cycle();
    set_cfg(800, 900, 3, 1, 0, 0);
    repeat (5000) cycle();

    // asynchronous reset mid-line, resume with default timing
    set_cfg(VGA_DEF_H_TOTAL, VGA_DEF_H_SYNC, VGA_DEF_V_TOTAL, VGA_DEF_V_SYNC, 0, 0);
    run_until_h(450, 3000);
    async_reset_pulse();
    repeat (900) cycle();

    // randomized enable, configuration and reset traffic
    for (int i = 0; i < 30000; i++) begin
      if (en && $urandom_range(0, 499) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      if ($urandom_range(0, 299) == 0) rand_cfg();
      if ($urandom_range(0, 5999) == 0) async_reset_pulse();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
